// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Bridges a simple valid/ready command/response interface onto an APB
// requester port. One transfer is outstanding at a time:
// IDLE -> SETUP -> ACCESS (wait states) -> RESP -> IDLE.
//
// Parameters
//   AW       APB address width
//   DW       APB data width
//   TIMEOUT  maximum number of consecutive ACCESS cycles with pready low
//            before the transfer is abandoned; 0 disables the timeout
//
// Ports
//   pclk, preset                 clock (rising edge) and synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata command payload, captured on acceptance
//   rsp_valid/rsp_ready          response handshake (rsp_valid only in RESP)
//   rsp_rdata/rsp_slverr/
//   rsp_timeout                  response payload, held until handshake
//   psel/penable/pwrite/
//   paddr/pwdata                 APB requester outputs
//   prdata/pready/pslverr        APB completer inputs
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          preset,
  // command side
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  // response side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_slverr,
  output logic          rsp_timeout,
  // APB requester
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  // The counter holds the number of wait cycles already spent, so the
  // current wait cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [1:0]    state_q,       state_d;
  logic [CW-1:0] wait_cnt_q,    wait_cnt_d;
  logic          pwrite_q,      pwrite_d;
  logic [AW-1:0] paddr_q,       paddr_d;
  logic [DW-1:0] pwdata_q,      pwdata_d;
  logic [DW-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic          rsp_slverr_q,  rsp_slverr_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone accepts.
        if (cmd_valid) begin
          state_d    = ST_SETUP;
          pwrite_d   = cmd_write;
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_wdata;
          wait_cnt_d = '0;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready wins over an expiring timeout in the same cycle.
        if (pready) begin
          state_d       = ST_RESP;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (TO_EN && (wait_cnt_q == WAIT_LAST)) begin
          state_d       = ST_RESP;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // All handshake and APB strobes decode from the state register only.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Self-checking bench for apb_master_bridge. A table of transfer records
// (command, completer behaviour, response stall, expected response) is
// applied in a loop; the expected response is queued when the command is
// accepted and compared when the response handshake happens. A hand-written
// sequence covers reset in the middle of ACCESS. APB protocol properties are
// checked continuously by concurrent assertions.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int AW      = 6;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int NVEC    = 8;

  logic          pclk;
  logic          preset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_master_bridge #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------------------------------------------------------------------
  // APB protocol properties
  // ---------------------------------------------------------------------------
  a_known: assert property (@(posedge pclk) disable iff (preset)
    !$isunknown({psel, penable, pwrite, paddr, pwdata, cmd_ready, rsp_valid}))
    else $error("FAIL assert_known: unknown value on a DUT output");
  a_en_needs_sel: assert property (@(posedge pclk) disable iff (preset)
    penable |-> psel)
    else $error("FAIL assert_penable_psel: penable=1 with psel=0");
  a_setup_to_access: assert property (@(posedge pclk) disable iff (preset)
    (psel && !penable) |=> (psel && penable))
    else $error("FAIL assert_setup_access: SETUP not followed by ACCESS");
  a_sel_rise: assert property (@(posedge pclk) disable iff (preset)
    $rose(psel) |-> !penable)
    else $error("FAIL assert_sel_rise: psel rose together with penable");
  a_stable_setup: assert property (@(posedge pclk) disable iff (preset)
    (psel && !penable) |=> ($stable(paddr) && $stable(pwdata) && $stable(pwrite)))
    else $error("FAIL assert_stable_setup: payload changed SETUP->ACCESS");
  a_stable_wait: assert property (@(posedge pclk) disable iff (preset)
    (penable && !pready) |=> ($stable(paddr) && $stable(pwdata) && $stable(pwrite)))
    else $error("FAIL assert_stable_wait: payload changed during wait");
  a_done: assert property (@(posedge pclk) disable iff (preset)
    (penable && pready) |=> !psel)
    else $error("FAIL assert_done: psel still high after completion");
  a_resp_no_sel: assert property (@(posedge pclk) disable iff (preset)
    rsp_valid |-> !psel)
    else $error("FAIL assert_resp_no_sel: psel high while rsp_valid");

  // ---------------------------------------------------------------------------
  // Vector table and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;      // ACCESS cycles with pready low before pready high
    logic [DW-1:0] prdata;
    logic          pslverr;
    int            rsp_delay;  // cycles rsp_ready held low in RESP
    logic          hold;       // keep cmd_valid high during the RESP stall
    logic [DW-1:0] exp_rdata;
    logic          exp_slverr;
    logic          exp_to;
    int            exp_acc;    // expected number of ACCESS cycles
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          to;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   chk_cnt;
  int   err_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Runs one table record; entered and left one time unit after a clock edge
  // with the DUT in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int            n;
    int            acc;
    int            lat;
    bit            stable_ok;
    bit            stall_ok;
    logic [DW+1:0] snap;
    exp_t          e;

    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_bound", 64'(n < 50), 64'(1));
    if (n >= 50) return;

    tick();  // accept edge
    sb_q.push_back('{rdata: v.exp_rdata, slverr: v.exp_slverr, to: v.exp_to});
    lat = 1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;

    // SETUP: completer inputs are junk and must be ignored
    check("setup_strobes", 64'({psel, penable, rsp_valid}), 64'(3'b100));
    check("setup_payload", 64'({pwrite, paddr, pwdata}), 64'({v.wr, v.addr, v.wdata}));
    pready  = 1'($urandom);
    prdata  = $urandom;
    pslverr = 1'($urandom);
    tick();
    lat++;

    acc = 0;
    stable_ok = 1'b1;
    while (penable && acc < 64) begin
      acc++;
      if ({psel, rsp_valid, pwrite, paddr, pwdata} !== {1'b1, 1'b0, v.wr, v.addr, v.wdata})
        stable_ok = 1'b0;
      if (acc > v.waits) begin
        pready  = 1'b1;
        prdata  = v.prdata;
        pslverr = v.pslverr;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
      tick();
      lat++;
    end
    check("access_cycles", 64'(acc), 64'(v.exp_acc));
    check("access_payload_stable", 64'(stable_ok), 64'(1));
    check("accept_to_rsp_latency", 64'(lat), 64'(v.exp_acc + 2));
    check("resp_strobes", 64'({rsp_valid, psel, penable, cmd_ready}), 64'(4'b1000));
    pready  = 1'b0;
    prdata  = $urandom;
    pslverr = 1'($urandom);

    snap = {rsp_rdata, rsp_slverr, rsp_timeout};
    rsp_ready = 1'b0;
    if (v.hold) cmd_valid = 1'b1;
    stall_ok = 1'b1;
    for (int i = 0; i < v.rsp_delay; i++) begin
      tick();
      if (!rsp_valid || cmd_ready || psel || ({rsp_rdata, rsp_slverr, rsp_timeout} !== snap))
        stall_ok = 1'b0;
    end
    if (v.rsp_delay > 0) check("resp_stall_hold", 64'(stall_ok), 64'(1));

    // Handshake happens on the next edge: compare against the scoreboard.
    rsp_ready = 1'b1;
    e = sb_q.pop_front();
    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
    check("rsp_slverr", 64'(rsp_slverr), 64'(e.slverr));
    check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
    $display("txn %0d wr=%0d addr=0x%02h wdata=0x%08h acc=%0d rdata=0x%08h slverr=%0d timeout=%0d",
             idx, v.wr, v.addr, v.wdata, acc, rsp_rdata, rsp_slverr, rsp_timeout);
    tick();
    check("post_handshake", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit seen;

    chk_cnt = 0;
    err_cnt = 0;
    //            wr    addr    wdata         waits prdata        slv  dly hold exp_rdata     eslv eto acc
    vecs[0] = '{1'b1, 6'h3C, 32'hDEADBEEF,   0, 32'hCAFEF00D, 1'b0, 0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 6'h04, 32'h00000000,   3, 32'h12345678, 1'b1, 0, 1'b0, 32'h12345678, 1'b1, 1'b0, 4};
    vecs[2] = '{1'b0, 6'h10, 32'h11112222, 200, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 32'h00000000, 1'b1, 1'b1, TIMEOUT};
    vecs[3] = '{1'b0, 6'h10, 32'h33334444,  15, 32'hA5A50F0F, 1'b0, 0, 1'b0, 32'hA5A50F0F, 1'b0, 1'b0, TIMEOUT};
    vecs[4] = '{1'b1, 6'h2A, 32'h01234567,   1, 32'h76543210, 1'b1, 5, 1'b1, 32'h00000000, 1'b1, 1'b0, 2};
    vecs[5] = '{1'b0, 6'h3F, 32'h00000000,   0, 32'h89ABCDEF, 1'b0, 2, 1'b0, 32'h89ABCDEF, 1'b0, 1'b0, 1};
    vecs[6] = '{1'b1, 6'h00, 32'h00000000,  16, 32'h5A5A5A5A, 1'b0, 0, 1'b0, 32'h00000000, 1'b1, 1'b1, TIMEOUT};
    vecs[7] = '{1'b0, 6'h15, 32'h00000000,   2, 32'h0BADF00D, 1'b0, 1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 3};

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    repeat (3) tick();

    check("reset_apb", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
    check("reset_rsp", 64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}), 64'(0));
    preset = 1'b0;
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();

    for (int i = 0; i < NVEC - 1; i++) run_vec(i, vecs[i]);

    // Reset while a write sits in ACCESS wait states.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 6'h08;
    cmd_wdata = 32'h55AA55AA;
    pready    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("rst_mid_setup", 64'({psel, penable, paddr}), 64'({1'b1, 1'b0, 6'h08}));
    tick();
    check("rst_mid_access", 64'({psel, penable}), 64'(2'b11));
    tick();
    preset = 1'b1;
    tick();
    check("rst_abort_apb", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
    check("rst_abort_rsp", 64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}), 64'(0));
    preset = 1'b0;
    check("rst_abort_cmd_ready", 64'(cmd_ready), 64'(1));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
      tick();
      if (rsp_valid || psel) seen = 1'b1;
    end
    check("rst_no_response", 64'(seen), 64'(0));
    $display("txn reset_abort addr=0x08 rsp_valid_seen=%0d", seen);
    pready = 1'b0;

    run_vec(NVEC - 1, vecs[NVEC - 1]);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter AW, default 6, APB address width.
REQ-002 SHALL have parameter DW, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max consecutive ACCESS wait cycles; 0 disables timeout.
REQ-004 SHALL have port pclk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port preset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-007 SHALL have ports cmd_write input 1, cmd_addr input AW, cmd_wdata input DW: command payload.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-009 SHALL have ports rsp_rdata output DW, rsp_slverr output 1, rsp_timeout output 1: response payload.
REQ-010 SHALL have APB requester ports psel, penable, pwrite output 1; paddr output AW; pwdata output DW.
REQ-011 SHALL have APB completer-side inputs prdata input DW, pready input 1, pslverr input 1.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, encoded in a single state register.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; command is accepted on an edge where cmd_valid & cmd_ready, then IDLE->SETUP.
REQ-014 SHALL, on acceptance, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata.
REQ-015 SHALL hold pwrite/paddr/pwdata stable from SETUP through the final ACCESS cycle, and keep the last values in RESP and IDLE.
REQ-016 SHALL drive psel=1, penable=0 in SETUP; SETUP always lasts exactly one cycle, then ACCESS.
REQ-017 SHALL drive psel=1, penable=1 in ACCESS; psel/penable SHALL be 0 in IDLE and RESP, and SHALL be decoded from registered state only (no combinational path from inputs).
REQ-018 SHALL, in ACCESS with pready=1: capture rsp_slverr=pslverr, rsp_rdata=prdata for reads and 0 for writes, rsp_timeout=0, then ACCESS->RESP.
REQ-019 SHALL count consecutive ACCESS cycles with pready=0 using a counter cleared on entry to SETUP.
REQ-020 SHALL, when TIMEOUT>0 and the counter reaches TIMEOUT with pready=0, move to RESP with rsp_timeout=1, rsp_slverr=1, rsp_rdata=0.
REQ-021 SHALL give pready=1 priority over timeout when both occur in the same cycle.
REQ-022 SHALL assert rsp_valid only in RESP, holding rsp_rdata/rsp_slverr/rsp_timeout stable until rsp_valid & rsp_ready, then RESP->IDLE.
REQ-023 SHALL ignore prdata/pslverr values (including X) outside ACCESS-with-pready and prdata on writes.
REQ-024 SHALL, with zero wait states, assert rsp_valid 3 cycles after the command-accept edge; minimum 4 cycles per transfer with rsp_ready tied high.
REQ-025 SHALL never accept a new command before the prior response handshake completes (one outstanding transfer).

Reset
REQ-026 SHALL, on any edge with preset=1, force state=IDLE, counter=0, and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout to 0; cmd_ready reads 1 once preset is deasserted.
REQ-027 SHALL abort any in-progress transfer on reset without emitting a response; psel/penable low in the cycle after the reset edge.

Verification
REQ-028 Write addr=0x3C data=0xDEADBEEF, pready=1 immediately -> psel 2 cycles, penable 1 cycle, paddr/pwdata stable, rsp_valid 3 cycles after accept, slverr=0, rdata=0.
REQ-029 Read addr=0x04, pready low 3 cycles then high with prdata=0x12345678, pslverr=1 -> ACCESS lasts 4 cycles, rsp_rdata=0x12345678, rsp_slverr=1, rsp_timeout=0.
REQ-030 TIMEOUT=16, pready held 0 -> exit after 16 wait cycles, rsp_timeout=1, rsp_slverr=1, rsp_rdata=0; repeat with pready=1 on 16th cycle -> normal completion.
REQ-031 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp payload stable, cmd_ready=0 throughout, psel=0; next command accepted only after response handshake.
REQ-032 preset=1 asserted during ACCESS -> next cycle psel=penable=0, rsp_valid never asserted, all outputs 0; post-reset command completes normally.
REQ-033 Bench SHALL bind the APB protocol assertions (known signals, PADDR/PWDATA stability, PENABLE sequencing) on all scenarios with zero failures.
